// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fnd_pkg
// Description : Shared state encodings and BCD digit constants for the FND
//               stopwatch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fnd_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : 2-flop synchronizer, stability-count debouncer and one-cycle
//               rising-edge press pulse for a raw push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // The count only survives while the new level is held without a break.
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/fnd_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fnd_stopwatch_ctrl
// Description : Run/pause/clear stopwatch driving four BCD digits with an
//               up/down count stepped every TICK_DIV clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_stopwatch_ctrl
    import fnd_pkg::*;
#(
    parameter int TICK_DIV  = 10_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_btn_run,
    input  logic         i_btn_clear,
    input  logic         i_dir,
    output logic [3:0]   o_four,
    output logic [3:0]   o_three,
    output logic [3:0]   o_two,
    output logic [3:0]   o_one,
    output logic         o_running,
    output logic         o_wrap
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic             w_run_press;
    logic             w_clr_press;
    logic             w_run_level;
    logic             w_clr_level;
    logic             w_unused_levels;
    logic             r_dir_s1;
    logic             r_dir_s2;
    state_t           r_state;
    logic [TW-1:0]    r_tick;
    digit_t [3:0]     r_digits;
    digit_t [3:0]     w_next_digits;
    logic             w_step_wrap;
    logic             r_running;
    logic             r_wrap;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run_db (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_run),
        .o_level (w_run_level),
        .o_press (w_run_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_clear),
        .o_level (w_clr_level),
        .o_press (w_clr_press)
    );

    assign w_unused_levels = w_run_level ^ w_clr_level;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_dir_s1 <= 1'b0;
            r_dir_s2 <= 1'b0;
        end else begin
            r_dir_s1 <= i_dir;
            r_dir_s2 <= r_dir_s1;
        end
    end

    // Ripple carry/borrow through the digits; a carry out of the top digit is a wrap.
    always_comb begin
        logic carry;
        carry         = 1'b1;
        w_next_digits = r_digits;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r_dir_s2) begin
                    if (r_digits[i] == digit_t'(0)) begin
                        w_next_digits[i] = BCD_MAX;
                    end else begin
                        w_next_digits[i] = r_digits[i] - digit_t'(1);
                        carry            = 1'b0;
                    end
                end else begin
                    if (r_digits[i] >= BCD_MAX) begin
                        w_next_digits[i] = digit_t'(0);
                    end else begin
                        w_next_digits[i] = r_digits[i] + digit_t'(1);
                        carry            = 1'b0;
                    end
                end
            end
        end
        w_step_wrap = carry;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_tick    <= '0;
            r_digits  <= '0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_clr_press) begin
                r_state   <= ST_IDLE;
                r_tick    <= '0;
                r_digits  <= '0;
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_tick <= '0;
                        if (w_run_press) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (r_tick == TICK_LAST) begin
                            r_tick   <= '0;
                            r_digits <= w_next_digits;
                            r_wrap   <= w_step_wrap;
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                        if (w_run_press) begin
                            r_state   <= ST_PAUSE;
                            r_running <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        // Tick counter holds so the step phase resumes where it left off.
                        if (w_run_press) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_tick    <= '0;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_four    = r_digits[3];
    assign o_three   = r_digits[2];
    assign o_two     = r_digits[1];
    assign o_one     = r_digits[0];
    assign o_running = r_running;
    assign o_wrap    = r_wrap;

endmodule
`default_nettype wire

// File: doc/fnd_stopwatch_ctrl.md
Name: fnd_stopwatch_ctrl

Overview:
- Upstream value source for the 4-digit FND display path.
- Takes two raw push-buttons (run/pause, clear) and a direction switch.
- Runs a run/pause/clear state machine and a 4-digit BCD up/down counter stepped by an internal tick.
- Drives four BCD digits straight into the digit mux / BCD-to-FND decoder stage, replacing the binary counter plus digit divider.

Parameters:
- TICK_DIV, 10_000_000: i_clk cycles per count step (10 Hz at 100 MHz); legal range ≥2.
- DB_CYCLES, 1_000_000: cycles a synchronized button level must stay stable to be accepted (10 ms at 100 MHz); legal range ≥1.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-low reset
- i_btn_run  input  1  raw run/pause button, active-high, asynchronous to i_clk
- i_btn_clear  input  1  raw clear button, active-high, asynchronous to i_clk
- i_dir  input  1  raw level switch: 0 = count up, 1 = count down
- o_four  output  4  BCD thousands digit
- o_three  output  4  BCD hundreds digit
- o_two  output  4  BCD tens digit
- o_one  output  4  BCD ones digit
- o_running  output  1  high while state = RUN
- o_wrap  output  1  one-cycle pulse when the count wraps (9999->0000 up, 0000->9999 down)

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is asynchronous and active-low. While i_reset=0:
  - state = IDLE
  - all digits = 0
  - o_running = 0, o_wrap = 0
  - tick counter = 0
  - synchronizer and debounce registers = 0
- Input conditioning: each button and i_dir passes through a 2-flop synchronizer.
- Debounce (buttons only):
  - Debounced level changes only after the synchronized level has differed from it for DB_CYCLES consecutive cycles.
  - Any bounce restarts the stability count.
  - A rising edge of the debounced level produces a 1-cycle press pulse.
  - Latency from raw edge to press pulse: 2 + DB_CYCLES + 1 cycles.
- FSM state encoding: IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2. Code 2'd3 is illegal and recovers to IDLE next cycle.
- FSM transitions, evaluated on press pulses, taking effect on the next clock edge:
  - IDLE + run press -> RUN; tick counter cleared.
  - RUN + run press -> PAUSE.
  - PAUSE + run press -> RUN; tick counter keeps its value, so the step phase is preserved.
  - Clear press in any state -> IDLE with digits = 0000 and tick counter = 0.
  - Clear and run press in the same cycle: clear wins, run is ignored.
- Tick counter:
  - Counts 0..TICK_DIV-1 only in RUN; holds in PAUSE; is 0 in IDLE.
  - A step occurs on the cycle the counter reaches TICK_DIV-1. The counter returns to 0 and the digits update on that same clock edge.
- Step arithmetic (per-digit BCD; no binary-to-BCD conversion):
  - Up: ones+1. A digit that would become 10 becomes 0 and carries into the next digit.
  - Down: ones-1. A digit below 0 becomes 9 and borrows from the next digit.
  - Direction is sampled from synchronized i_dir at the step cycle.
- Wrap:
  - Up from 9999 -> 0000, and down from 0000 -> 9999.
  - o_wrap goes high for exactly the one cycle after the wrapping step edge; otherwise it is 0.
- Digit invariant: digits hold their value between steps and never leave the range 0–9.
- Mid-operation reset: asynchronous clear to the reset values above. The first press after release requires a full debounce period.

Decomposition:
- Shared constants file/package fnd_pkg:
  - FSM state encodings (ST_IDLE, ST_RUN, ST_PAUSE)
  - BCD_MAX = 4'd9
  - Digit width 4
- One sub-module, btn_debounce: 2-flop sync + stability counter + rising-edge pulse; parameter DB_CYCLES; ports i_clk, i_reset, i_btn, o_level, o_press.
  - Instantiated twice: run, clear.
  - i_dir uses a bare 2-flop sync in the parent.
- The BCD step logic stays inline in fnd_stopwatch_ctrl.

Test Plan: all scenarios run with TICK_DIV=5, DB_CYCLES=4.
1. Reset then run: release i_reset, hold i_btn_run high 10 cycles -> o_running=1 at cycle 8 after the raw edge; digits 0000->0001 five cycles later, then +1 every 5 cycles.
2. Bounce rejection: toggle i_btn_run every 2 cycles for 20 cycles, then return low -> no press pulse, state stays IDLE, digits 0000.
3. Pause/resume phase: run press, pause 2 cycles after a step (count 0003), wait 50 cycles, resume -> digits stay 0003 while paused; 0004 appears 3 cycles after resume takes effect.
4. Up wrap: force count to 9998 via steps (or preload in the bench) in RUN with i_dir=0 -> 9999 then 0000, o_wrap high exactly 1 cycle at the 0000 transition.
5. Down count/borrow: from 0100 with i_dir=1 -> next step 0099; from 0000 -> 9999 with o_wrap pulse.
6. Clear priority and async reset: run and clear pressed in the same cycle while RUN at 0042 -> IDLE, 0000, o_running=0. Separately, assert i_reset mid-count -> all outputs 0 immediately, without waiting for a clock edge.
